// File: rtl/xc_mp_alu.sv
// XCrypto multi-precision ALU: madd.3/msub.3/macc.1 combinational, mmul.3 via shift-add FSM.
// Define XC_MP_RADIX4_EN to retire two multiplier bits per MUL cycle.
module xc_mp_alu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            flush,
    input  logic            valid,
    output logic            ready,
    input  logic            op_madd_3,
    input  logic            op_msub_3,
    input  logic            op_macc_1,
    input  logic            op_mmul_3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] rs3,
    output logic [XLEN-1:0] result_lo,
    output logic [XLEN-1:0] result_hi
);

`ifdef XC_MP_RADIX4_EN
    localparam int unsigned CW = 4;
`else
    localparam int unsigned CW = 5;
`endif
    localparam logic [CW-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [2*XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic [2*XLEN-1:0]   fast_res;
    logic [2*XLEN-1:0]   pp;
    logic [2*XLEN-1:0]   res;
    logic                go;

    // Priority mmul > madd > msub > macc; mmul is handled by the FSM.
    always_comb begin
        fast_res = '0;
        if (op_madd_3) begin
            fast_res = {{XLEN{1'b0}}, rs1} + {{XLEN{1'b0}}, rs2}
                     + {{(2*XLEN-1){1'b0}}, rs3[0]};
        end else if (op_msub_3) begin
            fast_res = {{XLEN{1'b0}}, rs1} - {{XLEN{1'b0}}, rs2}
                     - {{(2*XLEN-1){1'b0}}, rs3[0]};
        end else if (op_macc_1) begin
            fast_res = {rs2, rs1} + {{XLEN{1'b0}}, rs3};
        end
    end

    always_comb begin
`ifdef XC_MP_RADIX4_EN
        case (mplier_q[1:0])
            2'd0:    pp = '0;
            2'd1:    pp = mcand_q;
            2'd2:    pp = mcand_q << 1;
            default: pp = mcand_q + (mcand_q << 1);
        endcase
`else
        pp = mplier_q[0] ? mcand_q : '0;
`endif
    end

    assign go = valid && !flush && g_resetn;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        ready    = 1'b0;
        res      = '0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    if (op_mmul_3) begin
                        acc_d    = {{XLEN{1'b0}}, rs3};
                        mcand_d  = {{XLEN{1'b0}}, rs1};
                        mplier_d = rs2;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        ready = 1'b1;
                        res   = fast_res;
                    end
                end
            end
            S_MUL: begin
                if (!go) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_q + pp;
`ifdef XC_MP_RADIX4_EN
                    mcand_d  = mcand_q << 2;
                    mplier_d = mplier_q >> 2;
`else
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
`endif
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (go) begin
                    ready = 1'b1;
                    res   = acc_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign result_lo = res[XLEN-1:0];
    assign result_hi = res[2*XLEN-1:XLEN];

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_xc_mp_alu.sv
// Self-checking bench for xc_mp_alu: directed cases plus random ops against an arithmetic model.
module tb_xc_mp_alu;

`ifdef XC_MP_RADIX4_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 33;
`endif

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        flush;
    logic        valid;
    logic        ready;
    logic        op_madd_3, op_msub_3, op_macc_1, op_mmul_3;
    logic [31:0] rs1, rs2, rs3;
    logic [31:0] result_lo, result_hi;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] last_res;

    xc_mp_alu #(.XLEN(32)) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .flush     (flush),
        .valid     (valid),
        .ready     (ready),
        .op_madd_3 (op_madd_3),
        .op_msub_3 (op_msub_3),
        .op_macc_1 (op_macc_1),
        .op_mmul_3 (op_mmul_3),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs3       (rs3),
        .result_lo (result_lo),
        .result_hi (result_hi)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // f = {mmul, madd, msub, macc}
    function automatic logic [63:0] model(input logic [3:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] c);
        if (f[3]) return 64'(a) * 64'(b) + 64'(c);
        if (f[2]) return 64'(a) + 64'(b) + 64'(c[0]);
        if (f[1]) return 64'(a) - 64'(b) - 64'(c[0]);
        if (f[0]) return {b, a} + 64'(c);
        return 64'd0;
    endfunction

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c);
        valid     = 1'b1;
        op_mmul_3 = f[3];
        op_madd_3 = f[2];
        op_msub_3 = f[1];
        op_macc_1 = f[0];
        rs1 = a;
        rs2 = b;
        rs3 = c;
    endtask

    task automatic run(input string tag, input logic [3:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c);
        int          cyc;
        int          busy_nz;
        int          exp_lat;
        logic        seen;
        logic [63:0] got;
        set_in(f, a, b, c);
        exp_lat = f[3] ? LAT : 0;
        cyc = 0; busy_nz = 0; seen = 1'b0; got = '0;
        while (!seen && cyc <= LAT + 4) begin
            @(negedge g_clk);
            if (ready) begin
                seen = 1'b1;
                got  = {result_hi, result_lo};
            end else begin
                if ({result_hi, result_lo} != 64'd0) busy_nz++;
                step();
                cyc++;
            end
        end
        last_res = got;
        chk({tag, "_ready"}, 64'(seen), 64'd1);
        chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_res"}, got, model(f, a, b, c));
        chk({tag, "_zero_busy"}, 64'(busy_nz), 64'd0);
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] f;
        g_resetn = 1'b0; flush = 1'b0; valid = 1'b0;
        op_madd_3 = 1'b0; op_msub_3 = 1'b0; op_macc_1 = 1'b0; op_mmul_3 = 1'b0;
        rs1 = '0; rs2 = '0; rs3 = '0;
        step(); step();
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_res", {result_hi, result_lo}, 64'd0);
        g_resetn = 1'b1;
        step();

        run("madd_carry", 4'b0100, 32'hFFFFFFFF, 32'h1, 32'h3);
        chk("madd_const", last_res, 64'h00000001_00000001);
        run("msub_wrap", 4'b0010, 32'h0, 32'h1, 32'h0);
        chk("msub_wrap_const", last_res, 64'hFFFFFFFF_FFFFFFFF);
        run("msub_small", 4'b0010, 32'h5, 32'h2, 32'h1);
        chk("msub_small_const", last_res, 64'h2);
        run("noop", 4'b0000, 32'h1234, 32'h5678, 32'h9);
        run("prio_all", 4'b1111, 32'hCAFEF00D, 32'h0BADBEEF, 32'h13579BDF);
        run("prio_madd", 4'b0111, 32'h80000000, 32'h80000000, 32'h1);
        run("prio_msub", 4'b0011, 32'h10, 32'h20, 32'h3);

        run("mmul_max", 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("mmul_max_const", last_res, 64'hFFFFFFFF_00000000);
        run("mmul_zero", 4'b1000, 32'h12345678, 32'h0, 32'hDEADBEEF);
        chk("mmul_zero_const", last_res, 64'h00000000_DEADBEEF);
        run("b2b_macc", 4'b0001, 32'hFFFFFFFF, 32'h1, 32'h1);
        chk("b2b_macc_const", last_res, 64'h00000002_00000000);

        // Fast op under flush must not retire.
        set_in(4'b0100, 32'h1, 32'h1, 32'h0);
        flush = 1'b1;
        @(negedge g_clk);
        chk("flush_fast_ready", 64'(ready), 64'd0);
        chk("flush_fast_res", {result_hi, result_lo}, 64'd0);
        step();
        flush = 1'b0;

        // mmul flushed in cycle 10; re-issue in cycle 11 must see full latency.
        set_in(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
        repeat (10) step();
        flush = 1'b1;
        @(negedge g_clk);
        chk("flush_mmul_ready", 64'(ready), 64'd0);
        step();
        flush = 1'b0;
        run("reissue", 4'b1000, 32'h3, 32'h7, 32'h1);
        chk("reissue_const", last_res, 64'h16);

        // valid dropped mid-MUL aborts the op.
        set_in(4'b1000, 32'hAAAA5555, 32'h5555AAAA, 32'h7);
        repeat (5) step();
        valid = 1'b0;
        @(negedge g_clk);
        chk("vdrop_ready", 64'(ready), 64'd0);
        step();
        run("after_vdrop", 4'b1000, 32'h0000FFFF, 32'hFFFF0000, 32'h1);

        // Async reset in cycle 20 of an mmul.
        set_in(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (20) step();
        g_resetn = 1'b0;
        #1;
        chk("rst_mid_ready", 64'(ready), 64'd0);
        chk("rst_mid_res", {result_hi, result_lo}, 64'd0);
        valid = 1'b0;
        step();
        g_resetn = 1'b1;
        step();
        run("post_rst_madd", 4'b0100, 32'h1, 32'h2, 32'h0);
        chk("post_rst_const", last_res, 64'h3);

        for (int i = 0; i < 24; i++) begin
            f = 4'($urandom_range(0, 15));
            run("rand", f, $urandom, $urandom, $urandom);
        end

        valid = 1'b0;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
